// File: rtl/cordic_nco_ctrl_pkg.sv
// Shared types and the quadrant fold for the CORDIC NCO controller.
// The fold works at DEFAULT_WIDTH; instances must use WIDTH <= DEFAULT_WIDTH.
package cordic_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef logic [1:0] quad_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    OUTPUT  = 2'd2,
    RELEASE = 2'd3
  } nco_state_t;

  typedef struct packed {
    logic signed [DEFAULT_WIDTH:0] cos_v;
    logic signed [DEFAULT_WIDTH:0] sin_v;
  } fold_t;

  // The extra sign bit means negating a full-scale magnitude cannot overflow.
  function automatic fold_t quad_fold(input quad_t quad,
                                      input logic [DEFAULT_WIDTH-1:0] x,
                                      input logic [DEFAULT_WIDTH-1:0] y);
    logic signed [DEFAULT_WIDTH:0] xs;
    logic signed [DEFAULT_WIDTH:0] ys;
    fold_t r;
    xs = {1'b0, x};
    ys = {1'b0, y};
    case (quad)
      2'd0: begin r.cos_v = xs;  r.sin_v = ys;  end
      2'd1: begin r.cos_v = -ys; r.sin_v = xs;  end
      2'd2: begin r.cos_v = -xs; r.sin_v = -ys; end
      2'd3: begin r.cos_v = ys;  r.sin_v = -xs; end
      default: begin r.cos_v = xs; r.sin_v = ys; end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cordic_nco_ctrl_if.sv
// Core handshake (start/angle/done/x/y) and sample valid/ready bundle.
interface cordic_nco_ctrl_if
  import cordic_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             cordic_start;
  logic [WIDTH-1:0] cordic_angle;
  logic             cordic_done;
  logic [WIDTH-1:0] cordic_x;
  logic [WIDTH-1:0] cordic_y;
  logic             sample_valid;
  logic             sample_ready;
  logic [WIDTH:0]   sample_cos;
  logic [WIDTH:0]   sample_sin;

  modport master (
    output cordic_start, cordic_angle, sample_valid, sample_cos, sample_sin,
    input  cordic_done, cordic_x, cordic_y, sample_ready
  );

  modport slave (
    input  cordic_start, cordic_angle, sample_valid, sample_cos, sample_sin,
    output cordic_done, cordic_x, cordic_y, sample_ready
  );
endinterface

// File: rtl/cordic_nco_ctrl_phase_acc.sv
// Full-circle phase accumulator; a load always beats a same-cycle advance.
module nco_phase_acc
  import cordic_pkg::*;
#(
  parameter int PHASE_W = DEFAULT_WIDTH + 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               advance,
  input  logic [PHASE_W-1:0] init,
  input  logic [PHASE_W-1:0] step,
  output logic [PHASE_W-1:0] phase
);

  // Phase register; the add wraps modulo 2^PHASE_W by construction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= {PHASE_W{1'b0}};
    end else if (load) begin
      phase <= init;
    end else if (advance) begin
      phase <= phase + step;
    end else begin
      phase <= phase;
    end
  end

endmodule

// File: rtl/cordic_nco_ctrl.sv
// NCO controller: issues first-quadrant angles to the cordic core and
// sign-corrects its magnitudes into signed cos/sin samples.
module cordic_nco_ctrl
  import cordic_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int PHASE_W = WIDTH + 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic               phase_load,
  input  logic [PHASE_W-1:0] phase_init,
  output logic               busy,
  cordic_nco_ctrl_if.master  bus
);

  nco_state_t         state;
  quad_t              quad;
  logic [PHASE_W-1:0] phase;
  logic               issue;
  fold_t              fold;

  nco_phase_acc #(.PHASE_W(PHASE_W)) u_phase_acc (
    .clk     (clk),
    .reset   (reset),
    .load    (phase_load),
    .advance (issue),
    .init    (phase_init),
    .step    (freq_word),
    .phase   (phase)
  );

  // Issue from IDLE, or from RELEASE only once the core has dropped a stale done.
  always_comb begin
    issue = 1'b0;
    case (state)
      IDLE:    issue = enable;
      RELEASE: issue = enable && !bus.cordic_done;
      default: issue = 1'b0;
    endcase
  end

  // Quadrant sign correction of the core magnitudes.
  always_comb begin
    fold = quad_fold(quad, DEFAULT_WIDTH'(bus.cordic_x), DEFAULT_WIDTH'(bus.cordic_y));
  end

  // Conversion FSM with registered handshake and sample outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      quad             <= 2'd0;
      busy             <= 1'b0;
      bus.cordic_start <= 1'b0;
      bus.cordic_angle <= {WIDTH{1'b0}};
      bus.sample_valid <= 1'b0;
      bus.sample_cos   <= {(WIDTH+1){1'b0}};
      bus.sample_sin   <= {(WIDTH+1){1'b0}};
    end else begin
      case (state)
        IDLE, RELEASE: begin
          if (issue) begin
            state            <= CONVERT;
            busy             <= 1'b1;
            bus.cordic_start <= 1'b1;
            bus.cordic_angle <= phase[WIDTH-1:0];
            quad             <= phase[PHASE_W-1:WIDTH];
          end else if (state == RELEASE && !bus.cordic_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= state;
          end
        end
        CONVERT: begin
          if (bus.cordic_done) begin
            state            <= OUTPUT;
            bus.cordic_start <= 1'b0;
            bus.sample_valid <= 1'b1;
            bus.sample_cos   <= fold.cos_v[WIDTH:0];
            bus.sample_sin   <= fold.sin_v[WIDTH:0];
          end else begin
            state <= CONVERT;
          end
        end
        OUTPUT: begin
          if (bus.sample_ready) begin
            state            <= RELEASE;
            bus.sample_valid <= 1'b0;
          end else begin
            state <= OUTPUT;
          end
        end
        default: begin
          state            <= IDLE;
          busy             <= 1'b0;
          bus.cordic_start <= 1'b0;
          bus.sample_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
